// File: rtl/fwd_pkg.sv
// Shared definitions for the writeback forwarding path: address width
// helper, the zero-register index and the default in-flight entry layout.
package fwd_pkg;

    // Width of a register address; a single-register file still gets one bit.
    function automatic int unsigned reg_addr_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int unsigned ZeroRegIndex     = 0;
    localparam int unsigned DefaultAddrWidth = 3;
    localparam int unsigned DefaultDataWidth = 16;

    // In-flight writeback entry at the default widths. Modules with other
    // widths declare the same {valid, addr, data} layout locally and hand it
    // to the read selector through its type parameter.
    typedef struct packed {
        logic                        valid;
        logic [DefaultAddrWidth-1:0] addr;
        logic [DefaultDataWidth-1:0] data;
    } fwd_entry_t;

endpackage

// File: rtl/bypass_read_select.sv
// One read port: picks the youngest matching in-flight stage, otherwise the
// register-file word, and reports which stage supplied the data.
module bypass_read_select
    import fwd_pkg::*;
#(
    parameter int unsigned ForwardDepth     = 2,
    parameter int unsigned RegAddrWidth     = 3,
    parameter int unsigned DataWidth        = 16,
    parameter int unsigned ZeroRegHardwired = 1,
    parameter type         EntryT           = fwd_entry_t
) (
    input  EntryT [ForwardDepth-1:0] stages,
    input  logic  [DataWidth-1:0]    regWord,
    input  logic  [RegAddrWidth-1:0] rdAddr,
    output logic  [DataWidth-1:0]    rdData,
    output logic  [ForwardDepth-1:0] fwdHit
);

    logic found;
    logic isZeroReg;

    assign isZeroReg = (ZeroRegHardwired != 0) && (rdAddr == RegAddrWidth'(ZeroRegIndex));

    // Priority scan from stage 0 (youngest) to the oldest stage.
    always_comb begin
        rdData = regWord;
        fwdHit = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < ForwardDepth; i++) begin
            if (!found && stages[i].valid && (stages[i].addr == rdAddr)) begin
                rdData    = stages[i].data;
                fwdHit[i] = 1'b1;
                found     = 1'b1;
            end
        end
        if (isZeroReg) begin
            rdData = '0;
            fwdHit = '0;
        end
    end

endmodule

// File: rtl/bypass_register_file.sv
// Architectural register file fronted by a ForwardDepth-deep pipeline of
// in-flight writeback results; read ports see the youngest pending value.
module bypass_register_file
    import fwd_pkg::*;
#(
    parameter int unsigned ReadPortCount    = 3,
    parameter int unsigned ForwardDepth     = 2,
    parameter int unsigned RegisterCount    = 8,
    parameter int unsigned DataWidth        = 16,
    parameter int unsigned ZeroRegHardwired = 1,
    localparam int unsigned RegAddrWidth    = reg_addr_width(RegisterCount)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         clk_en,
    input  logic                                         flush,
    input  logic                                         wr_valid,
    input  logic [RegAddrWidth-1:0]                      wr_addr,
    input  logic [DataWidth-1:0]                         wr_data,
    input  logic [ReadPortCount-1:0][RegAddrWidth-1:0]   rd_addr,
    output logic [ReadPortCount-1:0][DataWidth-1:0]      rd_data,
    output logic [ReadPortCount-1:0][ForwardDepth-1:0]   rd_fwd_hit,
    output logic                                         commit_valid,
    output logic [RegAddrWidth-1:0]                      commit_addr,
    output logic [DataWidth-1:0]                         commit_data
);

    typedef struct packed {
        logic                    valid;
        logic [RegAddrWidth-1:0] addr;
        logic [DataWidth-1:0]    data;
    } entry_t;

    entry_t [ForwardDepth-1:0]               stages;
    entry_t                                  incoming;
    logic   [DataWidth-1:0]                  regFile [RegisterCount];
    logic   [ReadPortCount-1:0][DataWidth-1:0] rfWord;
    logic                                    lastInRange;

    // Stage-entry record; writes to the hardwired zero register never enter.
    always_comb begin
        incoming.valid = wr_valid &&
            !((ZeroRegHardwired != 0) && (wr_addr == RegAddrWidth'(ZeroRegIndex)));
        incoming.addr  = wr_addr;
        incoming.data  = wr_data;
    end

    assign lastInRange  = 32'(stages[ForwardDepth-1].addr) < RegisterCount;
    assign commit_valid = stages[ForwardDepth-1].valid;
    assign commit_addr  = stages[ForwardDepth-1].addr;
    assign commit_data  = stages[ForwardDepth-1].data;

    // Stage shift, commit of the oldest stage, flush squash and reset.
    // A flush only drops valid bits, so the oldest entry never reaches the
    // register file at that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages <= '0;
            for (int unsigned r = 0; r < RegisterCount; r++) begin
                regFile[r] <= '0;
            end
        end else if (clk_en) begin
            if (flush) begin
                for (int unsigned i = 0; i < ForwardDepth; i++) begin
                    stages[i].valid <= 1'b0;
                end
            end else begin
                if (stages[ForwardDepth-1].valid && lastInRange) begin
                    regFile[stages[ForwardDepth-1].addr] <= stages[ForwardDepth-1].data;
                end
                stages[0] <= incoming;
                for (int unsigned i = 1; i < ForwardDepth; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end
    end

    for (genvar p = 0; p < ReadPortCount; p++) begin : gReadPort
        assign rfWord[p] = (32'(rd_addr[p]) < RegisterCount) ? regFile[rd_addr[p]] : '0;

        bypass_read_select #(
            .ForwardDepth    (ForwardDepth),
            .RegAddrWidth    (RegAddrWidth),
            .DataWidth       (DataWidth),
            .ZeroRegHardwired(ZeroRegHardwired),
            .EntryT          (entry_t)
        ) uSelect (
            .stages (stages),
            .regWord(rfWord[p]),
            .rdAddr (rd_addr[p]),
            .rdData (rd_data[p]),
            .fwdHit (rd_fwd_hit[p])
        );
    end

endmodule

// File: tb/tb_bypass_register_file.sv
// Self-checking bench for bypass_register_file: an age-based in-flight
// write list plus architectural register array predicts every output each
// cycle, and directed literal checks pin the model to known values.
module tb_bypass_register_file;

    localparam int RP = 3;
    localparam int FD = 2;
    localparam int RC = 8;
    localparam int AW = 3;
    localparam int DW = 16;

    logic                   clk;
    logic                   rstN;
    logic                   clkEn;
    logic                   flush;
    logic                   wrValid;
    logic [AW-1:0]          wrAddr;
    logic [DW-1:0]          wrData;
    logic [RP-1:0][AW-1:0]  rdAddr;
    logic [RP-1:0][DW-1:0]  rdData;
    logic [RP-1:0][FD-1:0]  rdHit;
    logic                   commitValid;
    logic [AW-1:0]          commitAddr;
    logic [DW-1:0]          commitData;

    int passCount  = 0;
    int checkCount = 0;
    bit cmpOn      = 1'b0;

    bypass_register_file #(
        .ReadPortCount   (RP),
        .ForwardDepth    (FD),
        .RegisterCount   (RC),
        .DataWidth       (DW),
        .ZeroRegHardwired(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .clk_en      (clkEn),
        .flush       (flush),
        .wr_valid    (wrValid),
        .wr_addr     (wrAddr),
        .wr_data     (wrData),
        .rd_addr     (rdAddr),
        .rd_data     (rdData),
        .rd_fwd_hit  (rdHit),
        .commit_valid(commitValid),
        .commit_addr (commitAddr),
        .commit_data (commitData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: writes in flight, each with its age in enabled edges since acceptance.
    typedef struct {
        int addr;
        int data;
        int age;
    } rec_t;

    rec_t inflight[$];
    int   modelRegs[RC];

    initial begin
        for (int r = 0; r < RC; r++) modelRegs[r] = 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Advance the model on every clock edge from the inputs it sees.
    always @(posedge clk) begin
        rec_t keep[$];
        if (!rstN) begin
            inflight.delete();
            for (int r = 0; r < RC; r++) modelRegs[r] = 0;
        end else if (clkEn) begin
            if (flush) begin
                inflight.delete();
            end else begin
                keep.delete();
                foreach (inflight[k]) begin
                    if (inflight[k].age == FD - 1) begin
                        modelRegs[inflight[k].addr] = inflight[k].data;
                    end else begin
                        rec_t r;
                        r = inflight[k];
                        r.age = r.age + 1;
                        keep.push_back(r);
                    end
                end
                inflight = keep;
                if (wrValid && wrAddr != 0) begin
                    rec_t n;
                    n.addr = int'(wrAddr);
                    n.data = int'(wrData);
                    n.age  = 0;
                    inflight.push_back(n);
                end
            end
        end
    end

    // Compare every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmpOn) begin
            bit expCv;
            int expCa;
            int expCd;
            expCv = 1'b0;
            expCa = 0;
            expCd = 0;
            for (int p = 0; p < RP; p++) begin
                int a;
                int bestAge;
                int d;
                logic [31:0] h;
                a = int'(rdAddr[p]);
                bestAge = FD;
                d = modelRegs[a];
                h = 0;
                if (a != 0) begin
                    foreach (inflight[k]) begin
                        if (inflight[k].addr == a && inflight[k].age < bestAge) begin
                            bestAge = inflight[k].age;
                            d = inflight[k].data;
                        end
                    end
                    if (bestAge < FD) h = 32'(1) << bestAge;
                end else begin
                    d = 0;
                end
                chk($sformatf("model_rd_data[%0d]", p), 32'(rdData[p]), 32'(d));
                chk($sformatf("model_rd_hit[%0d]", p), 32'(rdHit[p]), h);
            end
            foreach (inflight[k]) begin
                if (inflight[k].age == FD - 1) begin
                    expCv = 1'b1;
                    expCa = inflight[k].addr;
                    expCd = inflight[k].data;
                end
            end
            chk("model_commit_valid", 32'(commitValid), 32'(expCv));
            if (expCv) begin
                chk("model_commit_addr", 32'(commitAddr), 32'(expCa));
                chk("model_commit_data", 32'(commitData), 32'(expCd));
            end
        end
    end

    // Advance one clock, then return 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrValid = 1'b1;
        wrAddr  = a;
        wrData  = d;
    endtask

    initial begin
        rstN    = 1'b0;
        clkEn   = 1'b0;
        flush   = 1'b0;
        wrValid = 1'b0;
        wrAddr  = '0;
        wrData  = '0;
        rdAddr  = '0;
        tick();
        tick();
        rstN  = 1'b1;
        clkEn = 1'b1;
        cmpOn = 1'b1;

        // Reset state
        for (int p = 0; p < RP; p++) rdAddr[p] = 3'd3;
        #1;
        for (int p = 0; p < RP; p++) begin
            chk("reset_rd_data", 32'(rdData[p]), 32'h0);
            chk("reset_rd_hit", 32'(rdHit[p]), 32'h0);
        end
        chk("reset_commit_valid", 32'(commitValid), 32'h0);
        chk("reset_commit_addr", 32'(commitAddr), 32'h0);
        chk("reset_commit_data", 32'(commitData), 32'h0);

        // Single write r3 through the pipeline
        write(3'd3, 16'hBEEF);
        tick();
        wrValid = 1'b0;
        #1;
        chk("r3_e1_data", 32'(rdData[0]), 32'hBEEF);
        chk("r3_e1_hit", 32'(rdHit[0]), 32'h1);
        chk("r3_e1_cv", 32'(commitValid), 32'h0);
        tick();
        #1;
        chk("r3_e2_hit", 32'(rdHit[0]), 32'h2);
        chk("r3_e2_cv", 32'(commitValid), 32'h1);
        chk("r3_e2_ca", 32'(commitAddr), 32'h3);
        chk("r3_e2_cd", 32'(commitData), 32'hBEEF);
        tick();
        #1;
        chk("r3_e3_data", 32'(rdData[0]), 32'hBEEF);
        chk("r3_e3_hit", 32'(rdHit[0]), 32'h0);

        // Back-to-back writes to r5: youngest wins on every port
        write(3'd5, 16'h1111);
        tick();
        write(3'd5, 16'h2222);
        tick();
        wrValid = 1'b0;
        for (int p = 0; p < RP; p++) rdAddr[p] = 3'd5;
        #1;
        for (int p = 0; p < RP; p++) begin
            chk("r5_young_data", 32'(rdData[p]), 32'h2222);
            chk("r5_young_hit", 32'(rdHit[p]), 32'h1);
        end
        tick();
        tick();
        #1;
        chk("r5_rf_data", 32'(rdData[1]), 32'h2222);
        chk("r5_rf_hit", 32'(rdHit[1]), 32'h0);

        // Clock enable low holds everything
        rdAddr[1] = 3'd4;
        write(3'd4, 16'h00AA);
        tick();
        wrValid = 1'b0;
        clkEn   = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            #1;
            chk("hold_hit", 32'(rdHit[1]), 32'h1);
            chk("hold_cv", 32'(commitValid), 32'h0);
        end
        clkEn = 1'b1;
        tick();
        tick();
        #1;
        chk("r4_rf_data", 32'(rdData[1]), 32'h00AA);
        chk("r4_rf_hit", 32'(rdHit[1]), 32'h0);

        // Flush one edge after writing r6
        rdAddr[2] = 3'd6;
        write(3'd6, 16'h5555);
        tick();
        wrValid = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_data", 32'(rdData[2]), 32'h0);
        chk("flush_hit", 32'(rdHit[2]), 32'h0);
        chk("flush_cv", 32'(commitValid), 32'h0);
        tick();
        tick();
        #1;
        chk("flush_rf_data", 32'(rdData[2]), 32'h0);

        // Flush with the last stage full: entry must not commit
        write(3'd6, 16'h6666);
        tick();
        wrValid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        #1;
        chk("flush_last_data", 32'(rdData[2]), 32'h0);

        // Flush ignored while clock enable is low
        rdAddr[0] = 3'd7;
        write(3'd7, 16'h7777);
        tick();
        wrValid = 1'b0;
        clkEn   = 1'b0;
        flush   = 1'b1;
        tick();
        clkEn = 1'b1;
        flush = 1'b0;
        #1;
        chk("gated_flush_hit", 32'(rdHit[0]), 32'h1);
        tick();
        tick();
        #1;
        chk("r7_rf_data", 32'(rdData[0]), 32'h7777);

        // Zero register is hardwired
        rdAddr[0] = 3'd0;
        write(3'd0, 16'hFFFF);
        tick();
        wrValid = 1'b0;
        #1;
        chk("r0_data", 32'(rdData[0]), 32'h0);
        chk("r0_hit", 32'(rdHit[0]), 32'h0);
        chk("r0_cv", 32'(commitValid), 32'h0);
        tick();
        #1;
        chk("r0_cv2", 32'(commitValid), 32'h0);
        tick();
        #1;
        chk("r0_data2", 32'(rdData[0]), 32'h0);

        // Reset with r2 in flight discards it and clears the file
        rdAddr[1] = 3'd2;
        rdAddr[2] = 3'd4;
        write(3'd2, 16'h1234);
        tick();
        wrValid = 1'b0;
        #1;
        chk("r2_fwd_data", 32'(rdData[1]), 32'h1234);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        #1;
        chk("rst_r2_data", 32'(rdData[1]), 32'h0);
        chk("rst_r2_hit", 32'(rdHit[1]), 32'h0);
        chk("rst_cv", 32'(commitValid), 32'h0);
        chk("rst_r4_data", 32'(rdData[2]), 32'h0);
        tick();
        tick();
        #1;
        chk("rst_r2_late", 32'(rdData[1]), 32'h0);

        tick();
        cmpOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
